// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM PIO output slave: one write per grant, then a HOLD pacing gap.
// Define PIO_ARB_READBACK_EN to add a READ cycle after each write that compares readdata (sticky o_mismatch).
module pio_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [1:0]                o_avm_address,
  output logic                      o_avm_chipselect,
  output logic                      o_avm_write_n,
  output logic [31:0]               o_avm_writedata,
  input  logic [31:0]               i_avm_readdata,
  output logic                      o_busy,
  output logic [CNT_W-1:0]          o_write_count,
  output logic                      o_mismatch
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_HOLD} state_t;

  state_t                r_state, w_next;
  logic [PW-1:0]         r_ptr;
  logic [HW-1:0]         r_hold;
  logic [NUM_REQ-1:0]    r_grant;
  logic                  r_cs, r_wn, r_busy, r_mis;
  logic [31:0]           r_wdata;
  logic [CNT_W-1:0]      r_count;

  logic                  w_found;
  logic [PW-1:0]         w_win, w_nptr;
  logic [PW:0]           w_sum;
  logic [DATA_W-1:0]     w_slice;
  logic                  w_unused;

  assign w_unused = ^i_avm_readdata;

  // Rotating priority scan starting at r_ptr; first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NUM_REQ)) w_sum = w_sum - (PW+1)'(NUM_REQ);
      if (!w_found && i_req[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PW-1:0];
      end
    end
    w_sum = {1'b0, w_win} + (PW+1)'(1);
    if (w_sum >= (PW+1)'(NUM_REQ)) w_sum = '0;
    w_nptr  = w_sum[PW-1:0];
    w_slice = i_req_data[w_win*DATA_W +: DATA_W];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_WRITE;
`ifdef PIO_ARB_READBACK_EN
      S_WRITE: w_next = S_READ;
`else
      S_WRITE: w_next = S_HOLD;
`endif
      S_READ:  w_next = S_HOLD;
      S_HOLD:  if (r_hold == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_grant <= '0;
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_count <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_grant <= '0;
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_ptr   <= w_nptr;
          r_grant <= NUM_REQ'(1) << w_win;
          r_cs    <= 1'b1;
          r_wn    <= 1'b0;
          r_wdata <= 32'(w_slice);
        end
        S_WRITE: begin
          r_count <= r_count + 1'b1;
          r_hold  <= HW'(HOLD_CYCLES - 1);
`ifdef PIO_ARB_READBACK_EN
          r_cs    <= 1'b1;
`endif
        end
        S_READ: begin
          r_hold <= HW'(HOLD_CYCLES - 1);
          if (i_avm_readdata[DATA_W-1:0] != r_wdata[DATA_W-1:0]) r_mis <= 1'b1;
        end
        S_HOLD: if (r_hold != '0) r_hold <= r_hold - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_grant          = r_grant;
  assign o_avm_address    = 2'd0;
  assign o_avm_chipselect = r_cs;
  assign o_avm_write_n    = r_wn;
  assign o_avm_writedata  = r_wdata;
  assign o_busy           = r_busy;
  assign o_write_count    = r_count;
`ifdef PIO_ARB_READBACK_EN
  assign o_mismatch       = r_mis;
`else
  assign o_mismatch       = 1'b0;
`endif

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Bench for pio_write_arbiter: directed scenarios plus random requests against a service-schedule model.
module tb_pio_write_arbiter;
  localparam int N = 4, DW = 8, HOLD = 4, CW = 4;
`ifdef PIO_ARB_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int BLEN = 1 + RB + HOLD;
  localparam int PERIOD = HOLD + 2 + RB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, corrupt;
  logic [N-1:0]  req;
  logic [7:0]    reqd [N];
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  grant;
  logic [1:0]    addr;
  logic          cs, wn, busy, mism;
  logic [31:0]   wdata, rdata;
  logic [CW-1:0] wcnt;
  logic [7:0]    pio_out;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_data[g*DW +: DW] = reqd[g];
  end

  pio_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_data(req_data),
    .o_grant(grant), .o_avm_address(addr), .o_avm_chipselect(cs), .o_avm_write_n(wn),
    .o_avm_writedata(wdata), .i_avm_readdata(rdata), .o_busy(busy),
    .o_write_count(wcnt), .o_mismatch(mism));

  // PIO slave: latches written byte; can be forced to return 0xFF.
  always @(posedge clk)
    if (reset) pio_out <= 8'h00;
    else if (cs && !wn) pio_out <= wdata[7:0];
  assign rdata = corrupt ? 32'hFF : {24'h0, pio_out};

  int n_chk = 0, n_err = 0, tcyc = 0;
  // Model: m_s = cycles since the write cycle began (-1 when idle)
  int m_s = -1, m_ptr = 0, m_cnt = 0, m_w = 0;
  logic [7:0] m_wd = 8'h00;
  bit m_mis = 1'b0;
  int act_g[$], act_t[$];
  logic [7:0] act_d[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, tcyc);
    end
  endtask

  task automatic step();
    logic [7:0] rd;
    @(posedge clk);
    tcyc++;
    rd = corrupt ? 8'hFF : m_wd;
    if (reset) begin
      m_s = -1; m_ptr = 0; m_cnt = 0; m_mis = 1'b0;
    end else if (m_s < 0) begin
      if (req != '0) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
        m_wd  = reqd[m_w];
        m_ptr = (m_w + 1) % N;
        m_s   = 0;
      end
    end else begin
      if (m_s == 0) m_cnt = (m_cnt + 1) % (1 << CW);
      if (RB == 1 && m_s == 1 && rd != m_wd) m_mis = 1'b1;
      m_s++;
      if (m_s == BLEN) m_s = -1;
    end
    @(negedge clk);
    chk("chipselect", 32'(cs), 32'((m_s == 0) || (RB == 1 && m_s == 1)));
    chk("write_n", 32'(wn), 32'(m_s != 0));
    chk("grant", 32'(grant), (m_s == 0) ? (32'd1 << m_w) : 32'd0);
    chk("busy", 32'(busy), 32'(m_s >= 0));
    chk("write_count", 32'(wcnt), 32'(m_cnt));
    chk("address", 32'(addr), 32'd0);
    chk("mismatch", 32'(mism), 32'(m_mis));
    if (m_s == 0) chk("writedata", wdata, {24'h0, m_wd});
    if (cs && !wn) begin
      act_g.push_back(int'(grant)); act_d.push_back(wdata[7:0]); act_t.push_back(tcyc);
    end
  endtask

  task automatic clear_log();
    act_g.delete(); act_d.delete(); act_t.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; step(); reset = 1'b0;
  endtask

  task automatic run_until(input int nw, input string tag);
    int budget;
    budget = 200;
    while (act_d.size() < nw && budget > 0) begin step(); budget--; end
    chk({tag, "_timeout"}, 32'(act_d.size()), 32'(nw));
  endtask

  initial begin
    logic [7:0] exp3 [5];
    int g3 [5], g4 [3];
    exp3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    g3   = '{1, 2, 4, 8, 1};
    g4   = '{8, 2, 8};
    corrupt = 1'b0; req = '0;
    for (int i = 0; i < N; i++) reqd[i] = 8'h00;
    reset = 1'b1; step(); step(); reset = 1'b0;

    // idle
    repeat (50) step();
    chk("idle_count", 32'(wcnt), 32'd0);

    // single pulse on requester 2
    clear_log();
    reqd[2] = 8'hA5; req = 4'b0100; step(); req = '0;
    repeat (10) step();
    chk("pulse_nwrites", 32'(act_d.size()), 32'd1);
    if (act_d.size() == 1) begin
      chk("pulse_data", 32'(act_d[0]), 32'hA5);
      chk("pulse_grant", 32'(act_g[0]), 32'd4);
    end
    chk("pulse_count", 32'(wcnt), 32'd1);
    chk("pulse_pio", 32'(pio_out), 32'hA5);

    // all four held from ptr=0
    do_reset(); clear_log();
    reqd = '{8'h11, 8'h22, 8'h33, 8'h44};
    req = 4'b1111;
    run_until(5, "rr4");
    req = '0;
    for (int i = 0; i < 5 && i < act_d.size(); i++) begin
      chk($sformatf("rr4_data%0d", i), 32'(act_d[i]), 32'(exp3[i]));
      chk($sformatf("rr4_grant%0d", i), 32'(act_g[i]), 32'(g3[i]));
      if (i > 0) chk($sformatf("rr4_gap%0d", i), 32'(act_t[i] - act_t[i-1]), 32'(PERIOD));
    end
    repeat (BLEN + 2) step();

    // requester 1 served, then 1 and 3 held: 3,1,3
    do_reset();
    req = 4'b0010; step(); req = 4'b1010; clear_log();
    run_until(3, "alt");
    req = '0;
    for (int i = 0; i < 3 && i < act_g.size(); i++)
      chk($sformatf("alt_grant%0d", i), 32'(act_g[i]), 32'(g4[i]));
    repeat (BLEN + 2) step();

    // reset during HOLD
    do_reset();
    reqd[2] = 8'h5A; req = 4'b0100; step(); req = '0;
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_count", 32'(wcnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    clear_log();
    reqd[0] = 8'h3C; reqd[3] = 8'h77; req = 4'b1001; step(); req = '0;
    repeat (10) step();
    chk("rst_nwrites", 32'(act_d.size()), 32'd1);
    if (act_d.size() == 1) chk("rst_data", 32'(act_d[0]), 32'h3C);

`ifdef PIO_ARB_READBACK_EN
    do_reset();
    corrupt = 1'b1; reqd[0] = 8'h0F; req = 4'b0001; step(); req = '0;
    repeat (3) step(); corrupt = 1'b0;
    chk("rb_mismatch_set", 32'(mism), 32'd1);
    reqd[1] = 8'h55; req = 4'b0010; step(); req = '0;
    repeat (10) step();
    chk("rb_mismatch_sticky", 32'(mism), 32'd1);
    do_reset();
    chk("rb_mismatch_clr", 32'(mism), 32'd0);
`endif

    // random traffic; enough writes to wrap the 4-bit counter
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && ($urandom % 4) == 0) reqd[i] = 8'($urandom);
      if (($urandom % 3) == 0) req = N'($urandom);
      corrupt = (($urandom % 8) == 0);
      reset = (($urandom % 400) == 0);
      step();
    end
    reset = 1'b0; corrupt = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
